// File: rtl/sha2_msg_sched_if.sv
// rtl/sha2_msg_sched_if.sv - padded-word input and schedule-word output streams of the SHA-256 message scheduler
interface sha2_msg_sched_if;
  logic        shaf_rvalid;
  logic [31:0] shaf_rdata;
  logic        shaf_rready;
  logic        w_valid;
  logic [31:0] w_data;
  logic [5:0]  w_round;
  logic        w_ready;

  modport master (
    output shaf_rvalid, shaf_rdata, w_ready,
    input  shaf_rready, w_valid, w_data, w_round
  );

  modport slave (
    input  shaf_rvalid, shaf_rdata, w_ready,
    output shaf_rready, w_valid, w_data, w_round
  );
endinterface

// File: rtl/sha2_msg_sched.sv
// rtl/sha2_msg_sched.sv - collects 16 padded words and streams SHA-256 schedule words W[0..63]
module sha2_msg_sched #(
  parameter int NumRound   = 64,
  parameter int BlockWords = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sha_en,
  input  logic              hash_start,
  input  logic              wipe_secret,
  input  logic [31:0]       wipe_v,
  output logic              block_done,
  output logic              busy,
  sha2_msg_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StSched = 2'd2
  } state_e;

  localparam logic [3:0] LastFill  = 4'(BlockWords - 1);
  localparam logic [5:0] LastRound = 6'(NumRound - 1);

  state_e      state_q, state_d;
  logic [31:0] w_buf [BlockWords];
  logic [3:0]  fill_cnt;
  logic [5:0]  round;
  logic        fill_acc, sched_acc;
  logic [31:0] w_next;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // W[t+16] from the sliding window W[t..t+15] held in w_buf[0..15]
  assign w_next = w_buf[0] + sigma0(w_buf[1]) + w_buf[9] + sigma1(w_buf[14]);

  assign fill_acc     = bus.shaf_rvalid && bus.shaf_rready;
  assign sched_acc    = bus.w_valid && bus.w_ready;
  assign bus.w_data   = w_buf[0];
  assign bus.w_round  = round;
  assign busy         = (state_q == StFill) || (state_q == StSched);

  always_comb begin
    state_d         = state_q;
    bus.shaf_rready = 1'b0;
    bus.w_valid     = 1'b0;
    case (state_q)
      StIdle: ;
      StFill: begin
        bus.shaf_rready = sha_en;
        if (fill_acc && fill_cnt == LastFill) state_d = StSched;
      end
      StSched: begin
        bus.w_valid = sha_en;
        if (sched_acc && round == LastRound) state_d = StFill;
      end
      default: state_d = StIdle;
    endcase
    // Later assignments carry higher priority: wipe > disable > start
    if (hash_start) state_d = StFill;
    if (!sha_en)    state_d = StIdle;
    if (wipe_secret) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BlockWords; i++) w_buf[i] <= '0;
      fill_cnt   <= '0;
      round      <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      if (wipe_secret) begin
        for (int i = 0; i < BlockWords; i++) w_buf[i] <= wipe_v;
        fill_cnt <= '0;
        round    <= '0;
      end else if (!sha_en || hash_start) begin
        fill_cnt <= '0;
        round    <= '0;
      end else if (fill_acc) begin
        for (int i = 0; i < BlockWords - 1; i++) w_buf[i] <= w_buf[i+1];
        w_buf[BlockWords-1] <= bus.shaf_rdata;
        fill_cnt <= fill_cnt + 4'd1;
      end else if (sched_acc) begin
        for (int i = 0; i < BlockWords - 1; i++) w_buf[i] <= w_buf[i+1];
        w_buf[BlockWords-1] <= w_next;
        round <= round + 6'd1;
        if (round == LastRound) block_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// tb/tb_sha2_msg_sched.sv - scoreboard bench for sha2_msg_sched
module tb_sha2_msg_sched;
  typedef logic [31:0] blk_t [16];

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        sha_en, hash_start, wipe_secret;
  logic [31:0] wipe_v;
  logic        block_done, busy;

  sha2_msg_sched_if bus ();

  sha2_msg_sched dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sha_en      (sha_en),
    .hash_start  (hash_start),
    .wipe_secret (wipe_secret),
    .wipe_v      (wipe_v),
    .block_done  (block_done),
    .busy        (busy),
    .bus         (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0, n_err = 0;
  logic [37:0] exp_q [$];
  int          done_cnt = 0, cyc = 0, first_cyc = 0;
  logic        bp_mode = 1'b0, stall_chk = 1'b0, lat_arm = 1'b0;
  logic        lat_seen = 1'b0, lat_done = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_d, obs_w [64];
  logic [5:0]  prev_r;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected(input blk_t b);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), w[t]});
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted
  task automatic feed_word(input logic [31:0] d);
    int t = 0;
    if (bp_mode) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    bus.shaf_rvalid = 1'b1;
    bus.shaf_rdata  = d;
    @(negedge clk_i);
    while (!bus.shaf_rready && t < 1000) begin
      t++;
      @(negedge clk_i);
    end
    if (t >= 1000) check_eq("rready_timeout", t, 0);
    @(posedge clk_i);
    #1;
    bus.shaf_rvalid = 1'b0;
  endtask

  task automatic feed_block(input blk_t b);
    for (int i = 0; i < 16; i++) feed_word(b[i]);
    push_expected(b);
  endtask

  task automatic rand_block(output blk_t b);
    for (int i = 0; i < 16; i++) b[i] = $urandom;
  endtask

  task automatic pulse_start();
    hash_start = 1'b1;
    @(posedge clk_i);
    #1;
    hash_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 2000) begin
      t++;
      @(negedge clk_i);
    end
    check_eq("blocks_done", done_cnt, target);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      bus.w_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk_i) begin
    logic [37:0] e;
    cyc++;
    if (rst_ni) begin
      if (lat_arm && !lat_seen && bus.shaf_rvalid && bus.shaf_rready) begin
        first_cyc = cyc;
        lat_seen  = 1'b1;
      end
      if (bus.w_valid) check_eq("rready_in_sched", bus.shaf_rready, 0);
      if (stall_chk && prev_stall && bus.w_valid) begin
        check_eq("stall_data", bus.w_data, prev_d);
        check_eq("stall_round", bus.w_round, prev_r);
      end
      if (bus.w_valid && bus.w_ready) begin
        obs_w[bus.w_round] = bus.w_data;
        if (exp_q.size() == 0) check_eq("w_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("w_round", bus.w_round, e[37:32]);
          check_eq("w_data", bus.w_data, e[31:0]);
        end
      end
      if (block_done) begin
        done_cnt++;
        if (lat_arm && !lat_done) begin
          check_eq("done_latency", cyc - first_cyc + 1, 81);
          lat_done = 1'b1;
        end
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_d     = bus.w_data;
      prev_r     = bus.w_round;
    end else prev_stall = 1'b0;
  end

  initial begin
    blk_t b, abc;
    int   t;
    rst_ni = 1'b0;
    sha_en = 1'b0; hash_start = 1'b0; wipe_secret = 1'b0; wipe_v = '0;
    bus.shaf_rvalid = 1'b0; bus.shaf_rdata = '0;

    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_w_valid", bus.w_valid, 0);
    check_eq("rst_rready", bus.shaf_rready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", block_done, 0);
    check_eq("rst_round", bus.w_round, 0);
    check_eq("rst_data", bus.w_data, 0);
    rst_ni = 1'b1;
    sha_en = 1'b1;
    @(posedge clk_i);
    #1;

    // SHA-256 "abc" single block
    abc[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) abc[i] = 32'h0;
    abc[15] = 32'h00000018;
    lat_arm = 1'b1;
    pulse_start();
    feed_block(abc);
    wait_done(1);
    check_eq("abc_w0", obs_w[0], 32'h61626380);
    check_eq("abc_w15", obs_w[15], 32'h00000018);
    check_eq("abc_w16", obs_w[16], 32'h61626380);
    check_eq("abc_w17", obs_w[17], 32'h000F0000);
    check_eq("abc_latency_seen", lat_done, 1);
    lat_arm = 1'b0;
    @(negedge clk_i);
    check_eq("abc_done_once", done_cnt, 1);
    check_eq("after_block_busy", busy, 1);
    @(posedge clk_i);
    #1;

    // Backpressure on both streams
    bp_mode = 1'b1;
    stall_chk = 1'b1;
    pulse_start();
    rand_block(b);
    feed_block(b);
    wait_done(2);
    stall_chk = 1'b0;
    bp_mode = 1'b0;
    @(posedge clk_i);
    #1;

    // Two back-to-back blocks with no new start
    rand_block(b);
    feed_block(b);
    rand_block(b);
    feed_block(b);
    wait_done(4);
    @(posedge clk_i);
    #1;

    // Restart after 7 words
    pulse_start();
    for (int i = 0; i < 7; i++) feed_word($urandom);
    pulse_start();
    @(negedge clk_i);
    check_eq("restart_fill_cnt", dut.fill_cnt, 0);
    @(posedge clk_i);
    #1;
    rand_block(b);
    feed_block(b);
    wait_done(5);
    @(posedge clk_i);
    #1;

    // Wipe at round 30
    pulse_start();
    rand_block(b);
    feed_block(b);
    t = 0;
    @(negedge clk_i);
    while (!(bus.w_valid && bus.w_round == 6'd30) && t < 500) begin
      t++;
      @(negedge clk_i);
    end
    check_eq("wipe_reached_r30", bus.w_round, 30);
    wipe_v = 32'hDEADBEEF;
    wipe_secret = 1'b1;
    @(posedge clk_i);
    #1;
    wipe_secret = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_eq("wipe_w_valid", bus.w_valid, 0);
    check_eq("wipe_busy", busy, 0);
    @(posedge clk_i);
    #1;
    pulse_start();
    @(negedge clk_i);
    check_eq("wipe_restart_busy", busy, 1);
    for (int i = 0; i < 16; i++) check_eq("wipe_buf", dut.w_buf[i], 32'hDEADBEEF);
    check_eq("wipe_no_done", done_cnt, 5);
    @(posedge clk_i);
    #1;

    // sha_en drop mid-fill
    for (int i = 0; i < 5; i++) feed_word($urandom);
    bus.shaf_rvalid = 1'b1;
    @(negedge clk_i);
    check_eq("en_rready_before", bus.shaf_rready, 1);
    sha_en = 1'b0;
    #1;
    check_eq("en_rready_same_cycle", bus.shaf_rready, 0);
    @(negedge clk_i);
    check_eq("en_busy", busy, 0);
    bus.shaf_rvalid = 1'b0;
    sha_en = 1'b1;
    repeat (4) @(negedge clk_i);
    check_eq("en_stays_idle", busy, 0);
    check_eq("en_no_done", done_cnt, 5);

    // Reset during the schedule phase
    @(posedge clk_i);
    #1;
    pulse_start();
    rand_block(b);
    feed_block(b);
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check_eq("mid_rst_w_valid", bus.w_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_round", bus.w_round, 0);
    check_eq("mid_rst_data", bus.w_data, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (80) @(negedge clk_i);
    check_eq("mid_rst_no_done", done_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
